// File: rtl/dyn_out_arbiter_rr.sv
// ----------------------------------------------------------------------------
// dyn_out_arbiter_rr
// Per-output-port wormhole arbiter for the dynamic network router. Picks one
// of five input buffers (0=N, 1=E, 2=S, 3=W, 4=Proc) round-robin, locks the
// output to it for a whole packet (header + head_len body flits), and drives
// the select of this output's five-input crossbar mux.
//
// Ports:
//   clk        clock
//   reset      synchronous, active-high reset
//   req        per-input head-flit valid
//   head_len   per-input header length field, slice i = [i*LEN_WIDTH +: LEN_WIDTH]
//   out_ready  downstream can accept a flit this cycle
//   sel        registered mux select, 0..4 = owner, NULL_SEL = idle
//   grant      combinational one-hot flit-consumed strobe to the input buffers
//   valid_out  a flit is transferred on the mux output this cycle (|grant)
//   busy       registered, high while a packet owns the output
// ----------------------------------------------------------------------------
module dyn_out_arbiter_rr #(
    parameter int unsigned LEN_WIDTH = 8,
    parameter logic [2:0]  NULL_SEL  = 3'd7
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [4:0]               req,
    input  logic [5*LEN_WIDTH-1:0]   head_len,
    input  logic                     out_ready,
    output logic [2:0]               sel,
    output logic [4:0]               grant,
    output logic                     valid_out,
    output logic                     busy
);

    localparam int unsigned N_IN  = 5;
    localparam int unsigned CNT_W = LEN_WIDTH + 1;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_ROUTE = 1'b1;

    logic [0:0]           state_q, state_d;
    logic [2:0]           sel_q,   sel_d;
    logic [2:0]           owner_q, owner_d;
    logic [2:0]           ptr_q,   ptr_d;
    logic [CNT_W-1:0]     cnt_q,   cnt_d;
    logic                 busy_q,  busy_d;

    logic [LEN_WIDTH-1:0] len_arr [N_IN];
    logic [3:0]           scan_idx;
    logic [2:0]           win;
    logic                 win_vld;
    logic                 xfer;
    logic [4:0]           grant_c;

    // Unpack the per-input length fields.
    always_comb begin
        for (int i = 0; i < N_IN; i++) begin
            len_arr[i] = head_len[i*LEN_WIDTH +: LEN_WIDTH];
        end
    end

    // Round-robin scan: first requesting input at or after the pointer, mod 5.
    always_comb begin
        win      = 3'd0;
        win_vld  = 1'b0;
        scan_idx = 4'd0;
        for (int k = 0; k < N_IN; k++) begin
            scan_idx = 4'(ptr_q) + 4'(k);
            if (scan_idx >= 4'(N_IN)) begin
                scan_idx = scan_idx - 4'(N_IN);
            end
            if (!win_vld && req[scan_idx[2:0]]) begin
                win_vld = 1'b1;
                win     = scan_idx[2:0];
            end
        end
    end

    // A flit moves only when the locked owner has one and downstream takes it.
    always_comb begin
        xfer    = (state_q == ST_ROUTE) && req[owner_q] && out_ready;
        grant_c = xfer ? 5'(5'd1 << owner_q) : 5'd0;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;

        case (state_q)
            ST_IDLE: begin
                sel_d  = NULL_SEL;
                busy_d = 1'b0;
                if (win_vld) begin
                    state_d = ST_ROUTE;
                    sel_d   = win;
                    owner_d = win;
                    busy_d  = 1'b1;
                    // Header plus body flits; one extra bit so all-ones cannot wrap.
                    cnt_d   = CNT_W'(len_arr[win]) + CNT_W'(1);
                end
            end

            ST_ROUTE: begin
                if (xfer) begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = ST_IDLE;
                        sel_d   = NULL_SEL;
                        busy_d  = 1'b0;
                        ptr_d   = (owner_q == 3'd4) ? 3'd0 : owner_q + 3'd1;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
                sel_d   = NULL_SEL;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            sel_q   <= NULL_SEL;
            owner_q <= 3'd0;
            ptr_q   <= 3'd0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
        end
    end

    assign sel       = sel_q;
    assign busy      = busy_q;
    assign grant     = grant_c;
    assign valid_out = |grant_c;

endmodule

// File: tb/tb_dyn_out_arbiter_rr.sv
// ----------------------------------------------------------------------------
// tb_dyn_out_arbiter_rr
// Table-driven bench for dyn_out_arbiter_rr: each record is one clock cycle of
// inputs with the sel/busy/grant expected during that cycle. Expected records
// are queued when driven and popped at the falling edge. A hand-written
// sequence covers the maximum-length packet.
// ----------------------------------------------------------------------------
module tb_dyn_out_arbiter_rr;

    localparam int unsigned LW = 8;

    logic            clk = 1'b0;
    logic            reset;
    logic [4:0]      req;
    logic [5*LW-1:0] head_len;
    logic            out_ready;
    logic [2:0]      sel;
    logic [4:0]      grant;
    logic            valid_out;
    logic            busy;

    dyn_out_arbiter_rr #(.LEN_WIDTH(LW), .NULL_SEL(3'd7)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .head_len  (head_len),
        .out_ready (out_ready),
        .sel       (sel),
        .grant     (grant),
        .valid_out (valid_out),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic            rst;
        logic [4:0]      req;
        logic [5*LW-1:0] len;
        logic            rdy;
        logic            chk;
        logic [2:0]      sel;
        logic            busy;
        logic [4:0]      grant;
        int              tag;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];
    int   vectors    = 0;
    int   miscompares = 0;
    bit   mon_en     = 1'b0;

    localparam logic [5*LW-1:0] L_ZERO = 40'h00_00_00_00_00;
    localparam logic [5*LW-1:0] L2_3   = 40'h00_00_03_00_00;
    localparam logic [5*LW-1:0] L1_2   = 40'h00_00_00_02_00;
    localparam logic [5*LW-1:0] L3_7   = 40'h00_07_00_00_00;

    function automatic void add(input logic rst, input logic [4:0] rq,
                                input logic [5*LW-1:0] ln, input logic rdy,
                                input logic chk, input logic [2:0] es,
                                input logic eb, input logic [4:0] eg);
        vec_t v;
        v.rst = rst; v.req = rq; v.len = ln; v.rdy = rdy; v.chk = chk;
        v.sel = es; v.busy = eb; v.grant = eg; v.tag = tbl.size();
        tbl.push_back(v);
    endfunction

    // Structural invariants checked on every cycle once out of reset.
    always @(negedge clk) begin
        if (mon_en && !reset) begin
            vectors++;
            if (!$onehot0(grant) || (valid_out != (|grant)) ||
                ((grant != 5'd0) && (grant != 5'(5'd1 << sel)))) begin
                miscompares++;
                $display("FAIL invariant t=%0t grant=%b valid_out=%b sel=%0d",
                         $time, grant, valid_out, sel);
            end
        end
    end

    initial begin : main
        vec_t e;
        int   ngrant;
        int   cyc;
        bit   busy_seen;

        reset = 1'b1; req = '0; head_len = '0; out_ready = 1'b1;

        // Reset then idle.
        add(1, 5'b00000, L_ZERO, 1, 0, 3'd7, 0, 5'b00000);
        for (int i = 0; i < 10; i++) add(0, 5'b00000, L_ZERO, 1, 1, 3'd7, 0, 5'b00000);

        // Single request on input 2, three body flits; next scan starts at 3.
        add(1, 5'b00000, L2_3, 1, 0, 3'd7, 0, 5'b00000);
        add(0, 5'b00100, L2_3, 1, 1, 3'd7, 0, 5'b00000);
        for (int i = 0; i < 4; i++) add(0, 5'b00100, L2_3, 1, 1, 3'd2, 1, 5'b00100);
        add(0, 5'b00000, L2_3, 1, 1, 3'd7, 0, 5'b00000);
        add(0, 5'b01100, L2_3, 1, 1, 3'd7, 0, 5'b00000);
        add(0, 5'b01100, L2_3, 1, 1, 3'd3, 1, 5'b01000);
        add(0, 5'b00000, L2_3, 1, 1, 3'd7, 0, 5'b00000);

        // All five requesting, single-flit packets: 0,7,1,7,2,7,3,7,4,7,0.
        add(1, 5'b11111, L_ZERO, 1, 0, 3'd7, 0, 5'b00000);
        for (int k = 0; k < 12; k++) begin
            if (k % 2 == 0) add(0, 5'b11111, L_ZERO, 1, 1, 3'd7, 0, 5'b00000);
            else add(0, 5'b11111, L_ZERO, 1, 1, 3'(((k - 1) / 2) % 5), 1,
                     5'(5'd1 << (((k - 1) / 2) % 5)));
        end

        // Back-pressure and gaps: owner 1 (len 2) while input 0 keeps requesting.
        add(1, 5'b00000, L1_2, 1, 0, 3'd7, 0, 5'b00000);
        add(0, 5'b00001, L1_2, 1, 1, 3'd7, 0, 5'b00000);
        add(0, 5'b00001, L1_2, 1, 1, 3'd0, 1, 5'b00001);
        add(0, 5'b00011, L1_2, 1, 1, 3'd7, 0, 5'b00000);
        add(0, 5'b00011, L1_2, 1, 1, 3'd1, 1, 5'b00010);
        add(0, 5'b00011, L1_2, 0, 1, 3'd1, 1, 5'b00000);
        add(0, 5'b00001, L1_2, 1, 1, 3'd1, 1, 5'b00000);
        add(0, 5'b00001, L1_2, 0, 1, 3'd1, 1, 5'b00000);
        add(0, 5'b00011, L1_2, 1, 1, 3'd1, 1, 5'b00010);
        add(0, 5'b00011, L1_2, 0, 1, 3'd1, 1, 5'b00000);
        add(0, 5'b00011, L1_2, 1, 1, 3'd1, 1, 5'b00010);
        add(0, 5'b00001, L1_2, 1, 1, 3'd7, 0, 5'b00000);
        add(0, 5'b00001, L1_2, 1, 1, 3'd0, 1, 5'b00001);
        add(0, 5'b00000, L1_2, 1, 1, 3'd7, 0, 5'b00000);

        // Reset mid-packet on owner 3; relock reloads length sampled at lock only.
        add(1, 5'b01000, L3_7, 1, 0, 3'd7, 0, 5'b00000);
        add(0, 5'b01000, L3_7, 1, 1, 3'd7, 0, 5'b00000);
        for (int i = 0; i < 3; i++) add(0, 5'b01000, L3_7, 1, 1, 3'd3, 1, 5'b01000);
        add(1, 5'b01000, L3_7, 1, 1, 3'd3, 1, 5'b01000);
        add(0, 5'b01000, L3_7, 1, 1, 3'd7, 0, 5'b00000);
        add(0, 5'b01000, L3_7, 1, 1, 3'd3, 1, 5'b01000);
        for (int i = 0; i < 7; i++) add(0, 5'b01000, L_ZERO, 1, 1, 3'd3, 1, 5'b01000);
        add(0, 5'b00000, L_ZERO, 1, 1, 3'd7, 0, 5'b00000);

        foreach (tbl[i]) begin
            @(posedge clk); #1;
            reset = tbl[i].rst; req = tbl[i].req;
            head_len = tbl[i].len; out_ready = tbl[i].rdy;
            if (tbl[i].chk) sb.push_back(tbl[i]);
            @(negedge clk);
            mon_en = 1'b1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                vectors++;
                if (sel !== e.sel || busy !== e.busy || grant !== e.grant ||
                    valid_out !== (|e.grant)) begin
                    miscompares++;
                    $display("FAIL vec%0d: sel=%0d busy=%b grant=%b vout=%b, want sel=%0d busy=%b grant=%b vout=%b",
                             e.tag, sel, busy, grant, valid_out, e.sel, e.busy, e.grant, |e.grant);
                end
            end
        end

        // Maximum length: head_len=255 on input 0 must give 256 grants.
        @(posedge clk); #1;
        reset = 1'b1; req = 5'b00000; head_len = L_ZERO; out_ready = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; req = 5'b00001; head_len = 40'h00_00_00_00_FF;
        @(negedge clk);
        vectors++;
        if (sel !== 3'd7 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL maxlen_idle: sel=%0d busy=%b, want sel=7 busy=0", sel, busy);
        end
        @(negedge clk);
        busy_seen = busy;
        ngrant = 0;
        cyc = 0;
        while (busy && cyc < 600) begin
            if (grant == 5'b00001) ngrant++;
            cyc++;
            @(negedge clk);
        end
        vectors++;
        if (!busy_seen || busy || ngrant != 256) begin
            miscompares++;
            $display("FAIL maxlen_grants: grants=%0d busy_seen=%b busy_end=%b, want grants=256 busy_seen=1 busy_end=0",
                     ngrant, busy_seen, busy);
        end
        vectors++;
        if (sel !== 3'd7) begin
            miscompares++;
            $display("FAIL maxlen_release: sel=%0d, want 7", sel);
        end
        req = 5'b00000;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
